// File: rtl/serial_sub_pkg.sv
// Shared state encoding and width limits for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_MIN = 2;
    localparam int SUB_WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: difference and borrow-out of x - y - bin.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < SUB_WIDTH_MIN || WIDTH > SUB_WIDTH_MAX) begin : g_bad_width
            $error("serial_subtractor: WIDTH out of range");
        end
    endgenerate

    sub_state_t       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-2:0] r_next;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             d;
    logic             bout;

    full_subtractor_cell u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (brw),
        .d    (d),
        .bout (bout)
    );

    // r_sh holds only the low WIDTH-1 result bits; the last bit goes straight to diff.
    generate
        if (WIDTH > 2) begin : g_rwide
            assign r_next = {d, r_sh[WIDTH-2:1]};
        end else begin : g_rnarrow
            assign r_next = d;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_next;
                    brw  <= bout;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        diff       <= {d, r_sh};
                        borrow_out <= bout;
`ifdef SERIAL_SUB_OVF_EN
                        // a_sh[0]/b_sh[0] are the operand sign bits on this last edge
                        ovf        <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
`endif
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
